pipelined_core_fwd: RTL and testbench
=====================================

// Module: pipelined_core_fwd
// PURPOSE
//  Parametrised 5-stage (IF/ID/EXE/MEM/WB) in-order core; successor to the fixed-width pipelined regfile datapath.
//  Adds EXE/MEM->EXE and MEM/WB->EXE forwarding, load-use stall, taken-branch flush, perf counters.
//  Instruction and data memories sit outside the core behind combinational-read ports.
//  Top-level CPU building block; feeds the debug/trace bench via the wb_* outputs.
// PARAMETERS
//  DSIZE   32  datapath / register width
//  ISIZE   32  PC and instruction-address width (word addressed, PC+1 per instruction)
//  ASIZE   5   register address width; NREGS = 2**ASIZE, r0 hardwired to 0
//  FWD_EN  1   1 = forwarding enabled; 0 = every RAW hazard on an in-flight writer stalls in ID
//  CNT_W   32  width of the cycle and retire counters
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  imem_addr   out  ISIZE  fetch address (= PC)
//  imem_data   in   32     instruction at imem_addr, same cycle
//  dmem_addr   out  DSIZE  data address (EXE/MEM ALU result)
//  dmem_wdata  out  DSIZE  store data (forwarded rt value)
//  dmem_wen    out  1      store strobe, MEM stage
//  dmem_ren    out  1      load strobe, MEM stage
//  dmem_rdata  in   DSIZE  load data, same cycle
//  wb_wen      out  1      register write this cycle
//  wb_waddr    out  ASIZE  register written
//  wb_wdata    out  DSIZE  value written
//  stall       out  1      load-use / RAW stall active in ID
//  flush       out  1      taken branch in EXE, IF/ID and ID/EXE squashed
//  cycle_cnt   out  CNT_W  cycles since reset, wraps to 0
//  retire_cnt  out  CNT_W  valid instructions leaving WB, wraps to 0
// BEHAVIOUR
//  Reset (rst=0, async): PC=0, all stage valid bits=0, counters=0, regfile all 0; every output 0 except imem_addr=0.
//  Decode (op=inst[31:26]): 000000 R-type, aluop=funct[2:0], dst=rd; 001000 ADDI; 100011 LW; 101011 SW;
//   000100 BEQ; any other opcode = NOP (valid, no writes). I-type dst=rt; imm = sign-extended inst[15:0].
//  ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, 1/0), 110 nor, 111 pass b. Mod 2**DSIZE.
//  IF/ID register holds {valid, PC+1, inst}; ID/EXE, EXE/MEM, MEM/WB carry valid + controls; bubble = valid 0.
//  WB: wdata = LW ? MEM/WB load data : MEM/WB ALU result; write suppressed when waddr=0 or valid=0.
//  Regfile write-first: ID read of the address written in WB the same cycle returns the new value.
//  Forwarding (FWD_EN=1), per ALU operand and store data: EXE/MEM match beats MEM/WB match beats ID/EXE value;
//   match = source valid & wen & waddr==src & src!=0; EXE/MEM source never a load (covered by stall).
//  Load-use: ID reads rs (all) or rt (R-type, BEQ, SW) == ID/EXE waddr of a valid LW -> stall 1 cycle:
//   PC and IF/ID hold, bubble into ID/EXE. FWD_EN=0: stall while any valid writer in EXE or MEM matches.
//  BEQ resolves in EXE: taken if forwarded operands equal; target = IF/ID PC+1 + imm (carried in ID/EXE).
//   Taken: PC<=target next cycle, IF/ID and ID/EXE become bubbles; 2-cycle penalty; not-taken costs 0.
//  Taken branch and stall same cycle: flush wins, stall ignored; flush has no effect on EXE/MEM or MEM/WB.
//  Branch latency: BEQ fetched at cycle t -> target fetched at t+3 when taken.
//  Latency: instruction fetched at t writes regfile at t+4; store/load access at t+3.
//  PC wraps modulo 2**ISIZE. Counters wrap modulo 2**CNT_W; retire_cnt counts MEM/WB valid incl. NOPs.
//  Reset mid-operation: all in-flight instructions discarded, no partial register or memory write.
// TESTING
//  1 Reset: rst=0 during activity -> imem_addr=0, wb_wen=0, counters 0; release -> fetch 0,1,2 on successive cycles.
//  2 Forwarding: ADDI r1,r0,5; ADD r2,r1,r1; SUB r3,r2,r1 back-to-back -> r2=10, r3=5, stall never 1, retire_cnt=3.
//  3 Load-use: mem[4]=7; LW r4,4(r0); ADD r5,r4,r4 -> stall=1 for exactly 1 cycle, r5=14; FWD_EN=0 rerun: r5=14, more stalls.
//  4 Branch: ADDI r1,r0,3; BEQ r1,r1,+2; ADDI r6,r0,1; ADDI r7,r0,1; ADDI r8,r0,9 -> flush 1 cycle, r6=r7=0, r8=9.
//  5 Not-taken BEQ r0,r1 and r0 writes: ADDI r0,r0,5 then ADD r9,r0,r0 -> no flush, r0 stays 0, r9=0.
//  6 Store forwarding + wrap: ADDI r2,r0,-1; SW r2,8(r0) -> dmem_wdata=0xFFFFFFFF, addr 8; CNT_W=4: cycle_cnt 15->0.

Source files
------------

// File: rtl/pipelined_core_fwd_if.sv
// Memory and writeback bus of pipelined_core_fwd: combinational-read instruction/data
// ports plus the retiring register write, seen from the core (master) or the system (slave).
interface pipelined_core_fwd_if #(
   parameter int DSIZE = 32,
   parameter int ISIZE = 32,
   parameter int ASIZE = 5
);
   logic [ISIZE-1:0] imem_addr;
   logic [31:0]      imem_data;
   logic [DSIZE-1:0] dmem_addr;
   logic [DSIZE-1:0] dmem_wdata;
   logic             dmem_wen;
   logic             dmem_ren;
   logic [DSIZE-1:0] dmem_rdata;
   logic             wb_wen;
   logic [ASIZE-1:0] wb_waddr;
   logic [DSIZE-1:0] wb_wdata;

   modport master (
      output imem_addr, input imem_data,
      output dmem_addr, output dmem_wdata, output dmem_wen, output dmem_ren,
      input  dmem_rdata,
      output wb_wen, output wb_waddr, output wb_wdata
   );

   modport slave (
      input  imem_addr, output imem_data,
      input  dmem_addr, input dmem_wdata, input dmem_wen, input dmem_ren,
      output dmem_rdata,
      input  wb_wen, input wb_waddr, input wb_wdata
   );
endinterface

// File: rtl/pipelined_core_fwd.sv
// 5-stage in-order core (IF/ID/EXE/MEM/WB) with EXE/MEM and MEM/WB forwarding,
// load-use stall, EXE-resolved BEQ with IF/ID + ID/EXE flush, cycle/retire counters.
module pipelined_core_fwd #(
   parameter int DSIZE  = 32,
   parameter int ISIZE  = 32,
   parameter int ASIZE  = 5,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   pipelined_core_fwd_if.master bus,
   output logic                 stall,
   output logic                 flush,
   output logic [CNT_W-1:0]     cycle_cnt,
   output logic [CNT_W-1:0]     retire_cnt
);
   localparam int unsigned NREGS = 2**ASIZE;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011,
      OP_BEQ   = 6'b000100
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_NOR, ALU_PASSB
   } aluop_e;

   logic [ISIZE-1:0] pc;
   logic [DSIZE-1:0] regs [NREGS];

   // IF/ID
   logic             ifid_valid;
   logic [ISIZE-1:0] ifid_pc1;
   logic [31:0]      ifid_inst;

   // decode
   logic [5:0]       id_op;
   logic [ASIZE-1:0] id_rs, id_rt, id_rd, id_waddr;
   logic             id_r, id_addi, id_lw, id_sw, id_beq, id_wen, id_alusrc, id_uses_rt;
   aluop_e           id_aluop;
   logic [DSIZE-1:0] id_imm, id_rs_val, id_rt_val;
   logic [ISIZE-1:0] id_target;

   // ID/EXE
   logic             idex_valid, idex_wen, idex_lw, idex_sw, idex_beq, idex_alusrc;
   logic [ASIZE-1:0] idex_waddr, idex_rs, idex_rt;
   aluop_e           idex_aluop;
   logic [DSIZE-1:0] idex_rs_val, idex_rt_val, idex_imm;
   logic [ISIZE-1:0] idex_target;

   // execute
   logic [DSIZE-1:0] fwd_a, fwd_b, alu_b, alu_res;
   logic             br_taken;

   // EXE/MEM
   logic             exmem_valid, exmem_wen, exmem_lw, exmem_sw;
   logic [ASIZE-1:0] exmem_waddr;
   logic [DSIZE-1:0] exmem_alu, exmem_sdata;

   // MEM/WB
   logic             memwb_valid, memwb_wen, memwb_lw;
   logic [ASIZE-1:0] memwb_waddr;
   logic [DSIZE-1:0] memwb_alu, memwb_ldata;

   logic             wb_we;
   logic [DSIZE-1:0] wb_data;
   logic             hazard, ld_hazard, raw_ex, raw_mem;
   logic             exmem_fwd_ok, memwb_fwd_ok;

   assign wb_data = memwb_lw ? memwb_ldata : memwb_alu;
   assign wb_we   = memwb_valid & memwb_wen & (memwb_waddr != '0);

   always_comb begin
      id_op      = ifid_inst[31:26];
      id_rs      = ASIZE'(ifid_inst[25:21]);
      id_rt      = ASIZE'(ifid_inst[20:16]);
      id_rd      = ASIZE'(ifid_inst[15:11]);
      id_imm     = DSIZE'($signed(ifid_inst[15:0]));
      id_target  = ifid_pc1 + ISIZE'($signed(ifid_inst[15:0]));
      id_r       = (id_op == OP_RTYPE);
      id_addi    = (id_op == OP_ADDI);
      id_lw      = (id_op == OP_LW);
      id_sw      = (id_op == OP_SW);
      id_beq     = (id_op == OP_BEQ);
      id_wen     = id_r | id_addi | id_lw;
      id_waddr   = id_r ? id_rd : id_rt;
      id_alusrc  = id_addi | id_lw | id_sw;
      id_uses_rt = id_r | id_beq | id_sw;
      id_aluop   = ALU_ADD;
      if (id_r)
         id_aluop = aluop_e'(ifid_inst[2:0]);
      else if (id_beq)
         id_aluop = ALU_SUB;
   end

   // write-first read: a WB write to the same register is visible to ID this cycle
   always_comb begin
      id_rs_val = regs[id_rs];
      id_rt_val = regs[id_rt];
      if (id_rs == '0)
         id_rs_val = '0;
      else if (wb_we && memwb_waddr == id_rs)
         id_rs_val = wb_data;
      if (id_rt == '0)
         id_rt_val = '0;
      else if (wb_we && memwb_waddr == id_rt)
         id_rt_val = wb_data;
   end

   always_comb begin
      ld_hazard = idex_valid & idex_lw & idex_wen & (idex_waddr != '0) &
                  ((id_rs == idex_waddr) | (id_uses_rt & (id_rt == idex_waddr)));
      raw_ex    = idex_valid & idex_wen & (idex_waddr != '0) &
                  ((id_rs == idex_waddr) | (id_uses_rt & (id_rt == idex_waddr)));
      raw_mem   = exmem_valid & exmem_wen & (exmem_waddr != '0) &
                  ((id_rs == exmem_waddr) | (id_uses_rt & (id_rt == exmem_waddr)));
      hazard    = ifid_valid & ((FWD_EN != 0) ? ld_hazard : (raw_ex | raw_mem));
   end

   always_comb begin
      exmem_fwd_ok = (FWD_EN != 0) & exmem_valid & exmem_wen & (exmem_waddr != '0);
      memwb_fwd_ok = (FWD_EN != 0) & memwb_valid & memwb_wen & (memwb_waddr != '0);
      fwd_a = idex_rs_val;
      if (exmem_fwd_ok && exmem_waddr == idex_rs)
         fwd_a = exmem_alu;
      else if (memwb_fwd_ok && memwb_waddr == idex_rs)
         fwd_a = wb_data;
      fwd_b = idex_rt_val;
      if (exmem_fwd_ok && exmem_waddr == idex_rt)
         fwd_b = exmem_alu;
      else if (memwb_fwd_ok && memwb_waddr == idex_rt)
         fwd_b = wb_data;
      alu_b = idex_alusrc ? idex_imm : fwd_b;
      case (idex_aluop)
         ALU_ADD: alu_res = fwd_a + alu_b;
         ALU_SUB: alu_res = fwd_a - alu_b;
         ALU_AND: alu_res = fwd_a & alu_b;
         ALU_OR:  alu_res = fwd_a | alu_b;
         ALU_XOR: alu_res = fwd_a ^ alu_b;
         ALU_SLT: alu_res = DSIZE'($signed(fwd_a) < $signed(alu_b));
         ALU_NOR: alu_res = ~(fwd_a | alu_b);
         default: alu_res = alu_b;
      endcase
      br_taken = idex_valid & idex_beq & (fwd_a == fwd_b);
   end

   assign flush = br_taken;
   assign stall = hazard & ~br_taken;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wb_we) begin
         regs[memwb_waddr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= '0;
         ifid_valid  <= 1'b0;
         ifid_pc1    <= '0;
         ifid_inst   <= '0;
         idex_valid  <= 1'b0;
         idex_wen    <= 1'b0;
         idex_lw     <= 1'b0;
         idex_sw     <= 1'b0;
         idex_beq    <= 1'b0;
         idex_alusrc <= 1'b0;
         idex_waddr  <= '0;
         idex_rs     <= '0;
         idex_rt     <= '0;
         idex_aluop  <= ALU_ADD;
         idex_rs_val <= '0;
         idex_rt_val <= '0;
         idex_imm    <= '0;
         idex_target <= '0;
         exmem_valid <= 1'b0;
         exmem_wen   <= 1'b0;
         exmem_lw    <= 1'b0;
         exmem_sw    <= 1'b0;
         exmem_waddr <= '0;
         exmem_alu   <= '0;
         exmem_sdata <= '0;
         memwb_valid <= 1'b0;
         memwb_wen   <= 1'b0;
         memwb_lw    <= 1'b0;
         memwb_waddr <= '0;
         memwb_alu   <= '0;
         memwb_ldata <= '0;
         cycle_cnt   <= '0;
         retire_cnt  <= '0;
      end else begin
         // flush outranks a simultaneous stall; EXE/MEM and MEM/WB always advance
         if (br_taken) begin
            pc         <= idex_target;
            ifid_valid <= 1'b0;
         end else if (!hazard) begin
            pc         <= pc + 1'b1;
            ifid_valid <= 1'b1;
            ifid_pc1   <= pc + 1'b1;
            ifid_inst  <= bus.imem_data;
         end

         idex_valid  <= ifid_valid & ~br_taken & ~hazard;
         idex_wen    <= id_wen;
         idex_lw     <= id_lw;
         idex_sw     <= id_sw;
         idex_beq    <= id_beq;
         idex_alusrc <= id_alusrc;
         idex_waddr  <= id_waddr;
         idex_rs     <= id_rs;
         idex_rt     <= id_rt;
         idex_aluop  <= id_aluop;
         idex_rs_val <= id_rs_val;
         idex_rt_val <= id_rt_val;
         idex_imm    <= id_imm;
         idex_target <= id_target;

         exmem_valid <= idex_valid;
         exmem_wen   <= idex_wen;
         exmem_lw    <= idex_lw;
         exmem_sw    <= idex_sw;
         exmem_waddr <= idex_waddr;
         exmem_alu   <= alu_res;
         exmem_sdata <= fwd_b;

         memwb_valid <= exmem_valid;
         memwb_wen   <= exmem_wen;
         memwb_lw    <= exmem_lw;
         memwb_waddr <= exmem_waddr;
         memwb_alu   <= exmem_alu;
         memwb_ldata <= bus.dmem_rdata;

         cycle_cnt <= cycle_cnt + 1'b1;
         if (memwb_valid)
            retire_cnt <= retire_cnt + 1'b1;
      end
   end

   assign bus.imem_addr  = pc;
   assign bus.dmem_addr  = exmem_alu;
   assign bus.dmem_wdata = exmem_sdata;
   assign bus.dmem_wen   = exmem_valid & exmem_sw;
   assign bus.dmem_ren   = exmem_valid & exmem_lw;
   assign bus.wb_wen     = wb_we;
   assign bus.wb_waddr   = memwb_waddr;
   assign bus.wb_wdata   = wb_data;
endmodule

// File: tb/tb_pipelined_core_fwd.sv
// Runs each program on a forwarding core and on a FWD_EN=0, CNT_W=4 core in parallel;
// register writes and stores are scoreboarded, stalls/flushes/counters checked per run.
module tb_pipelined_core_fwd;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipelined_core_fwd_if #(.DSIZE(32), .ISIZE(32), .ASIZE(5)) ifc0 ();
   pipelined_core_fwd_if #(.DSIZE(32), .ISIZE(32), .ASIZE(5)) ifc1 ();

   logic        stall0, flush0, stall1, flush1;
   logic [31:0] cyc_cnt0, ret_cnt0;
   logic [3:0]  cyc_cnt1, ret_cnt1;

   pipelined_core_fwd #(.DSIZE(32), .ISIZE(32), .ASIZE(5), .FWD_EN(1), .CNT_W(32)) dut0 (
      .clk(clk), .rst(rst), .bus(ifc0), .stall(stall0), .flush(flush0),
      .cycle_cnt(cyc_cnt0), .retire_cnt(ret_cnt0));

   pipelined_core_fwd #(.DSIZE(32), .ISIZE(32), .ASIZE(5), .FWD_EN(0), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .bus(ifc1), .stall(stall1), .flush(flush1),
      .cycle_cnt(cyc_cnt1), .retire_cnt(ret_cnt1));

   logic [31:0] imem  [256];
   logic [31:0] dmem0 [256];
   logic [31:0] dmem1 [256];

   assign ifc0.imem_data  = imem[ifc0.imem_addr[7:0]];
   assign ifc1.imem_data  = imem[ifc1.imem_addr[7:0]];
   assign ifc0.dmem_rdata = dmem0[ifc0.dmem_addr[7:0]];
   assign ifc1.dmem_rdata = dmem1[ifc1.dmem_addr[7:0]];

   logic [36:0] wbq0[$], wbq1[$];
   logic [63:0] stq0[$], stq1[$];

   int n_checks, n_fail;
   int stl0, stl1, fls0, fls1;
   logic [31:0] addr0 [64];
   logic [31:0] cyc0  [64];
   logic [31:0] cyc1  [64];
   logic [31:0] ret0  [64];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [2:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
      return {6'b000000, rs, rt, rd, 5'b00000, 3'b000, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic clear_all();
      for (int i = 0; i < 256; i++) begin
         imem[i]  = '0;
         dmem0[i] = '0;
         dmem1[i] = '0;
      end
      wbq0.delete(); wbq1.delete(); stq0.delete(); stq1.delete();
   endtask

   task automatic push_wb(input logic [4:0] a, input logic [31:0] d);
      wbq0.push_back({a, d});
      wbq1.push_back({a, d});
   endtask

   task automatic push_st(input logic [31:0] a, input logic [31:0] d);
      stq0.push_back({a, d});
      stq1.push_back({a, d});
   endtask

   task automatic watch(input int d, input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                        input logic sw, input logic [31:0] sa, input logic [31:0] sd);
      logic [36:0] e;
      logic [63:0] s;
      int sz;
      if (wen) begin
         sz = (d == 0) ? wbq0.size() : wbq1.size();
         if (sz == 0)
            check($sformatf("wb%0d_unexpected", d), 64'({wa, wd}), 64'd0);
         else begin
            if (d == 0) e = wbq0.pop_front(); else e = wbq1.pop_front();
            check($sformatf("wb%0d_write", d), 64'({wa, wd}), 64'(e));
         end
      end
      if (sw) begin
         if (d == 0) dmem0[sa[7:0]] = sd; else dmem1[sa[7:0]] = sd;
         sz = (d == 0) ? stq0.size() : stq1.size();
         if (sz == 0)
            check($sformatf("st%0d_unexpected", d), {sa, sd}, 64'd0);
         else begin
            if (d == 0) s = stq0.pop_front(); else s = stq1.pop_front();
            check($sformatf("st%0d_store", d), {sa, sd}, s);
         end
      end
   endtask

   // reset both cores, release on a negedge, then sample every negedge for ncyc cycles
   task automatic run_prog(input int ncyc);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      stl0 = 0; stl1 = 0; fls0 = 0; fls1 = 0;
      for (int k = 0; k <= ncyc; k++) begin
         if (k > 0) @(negedge clk);
         if (k < 64) begin
            addr0[k] = ifc0.imem_addr;
            cyc0[k]  = cyc_cnt0;
            cyc1[k]  = 32'(cyc_cnt1);
            ret0[k]  = ret_cnt0;
         end
         stl0 += int'(stall0); stl1 += int'(stall1);
         fls0 += int'(flush0); fls1 += int'(flush1);
         watch(0, ifc0.wb_wen, ifc0.wb_waddr, ifc0.wb_wdata, ifc0.dmem_wen, ifc0.dmem_addr, ifc0.dmem_wdata);
         watch(1, ifc1.wb_wen, ifc1.wb_waddr, ifc1.wb_wdata, ifc1.dmem_wen, ifc1.dmem_addr, ifc1.dmem_wdata);
      end
      check("wb0_pending", 64'(wbq0.size()), 64'd0);
      check("wb1_pending", 64'(wbq1.size()), 64'd0);
      check("st0_pending", 64'(stq0.size()), 64'd0);
      check("st1_pending", 64'(stq1.size()), 64'd0);
   endtask

   task automatic load_fwd_prog();
      imem[0] = itype(OP_ADDI, 5'd1, 5'd0, 16'd5);
      imem[1] = rtype(3'b000, 5'd2, 5'd1, 5'd1);
      imem[2] = rtype(3'b001, 5'd3, 5'd2, 5'd1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // reset asserted mid-run while a write is retiring
      clear_all();
      load_fwd_prog();
      wbq0.push_back({5'd1, 32'd5});
      wbq0.push_back({5'd2, 32'd10});
      wbq1.push_back({5'd1, 32'd5});
      run_prog(5);
      check("pre_reset_retire0", 64'(ret_cnt0), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_imem_addr0", 64'(ifc0.imem_addr), 64'd0);
      check("rst_imem_addr1", 64'(ifc1.imem_addr), 64'd0);
      check("rst_wb_wen0", 64'(ifc0.wb_wen), 64'd0);
      check("rst_cycle_cnt0", 64'(cyc_cnt0), 64'd0);
      check("rst_cycle_cnt1", 64'(cyc_cnt1), 64'd0);
      check("rst_retire_cnt0", 64'(ret_cnt0), 64'd0);

      // back-to-back dependent ALU ops
      clear_all();
      load_fwd_prog();
      push_wb(5'd1, 32'd5);
      push_wb(5'd2, 32'd10);
      push_wb(5'd3, 32'd5);
      run_prog(12);
      check("fetch_addr_k0", 64'(addr0[0]), 64'd0);
      check("fetch_addr_k1", 64'(addr0[1]), 64'd1);
      check("fetch_addr_k2", 64'(addr0[2]), 64'd2);
      check("fwd_stalls0", 64'(stl0), 64'd0);
      check("fwd_retire_k7", 64'(ret0[7]), 64'd3);
      check("fwd_stalls1", 64'(stl1), 64'd4);

      // load-use
      clear_all();
      dmem0[4] = 32'd7;
      dmem1[4] = 32'd7;
      imem[0] = itype(OP_LW, 5'd4, 5'd0, 16'd4);
      imem[1] = rtype(3'b000, 5'd5, 5'd4, 5'd4);
      push_wb(5'd4, 32'd7);
      push_wb(5'd5, 32'd14);
      run_prog(12);
      check("lu_stalls0", 64'(stl0), 64'd1);
      check("lu_stalls1", 64'(stl1), 64'd2);

      // taken branch skips three instructions, target = 1+1+3 = 5
      clear_all();
      imem[0] = itype(OP_ADDI, 5'd1, 5'd0, 16'd3);
      imem[1] = itype(OP_BEQ, 5'd1, 5'd1, 16'd3);
      imem[2] = itype(OP_ADDI, 5'd6, 5'd0, 16'd1);
      imem[3] = itype(OP_ADDI, 5'd7, 5'd0, 16'd1);
      imem[4] = itype(OP_ADDI, 5'd11, 5'd0, 16'd1);
      imem[5] = itype(OP_ADDI, 5'd8, 5'd0, 16'd9);
      push_wb(5'd1, 32'd3);
      push_wb(5'd8, 32'd9);
      run_prog(14);
      check("br_flush0", 64'(fls0), 64'd1);
      check("br_flush1", 64'(fls1), 64'd1);
      check("br_stalls1", 64'(stl1), 64'd2);
      check("br_fetch_k3", 64'(addr0[3]), 64'd3);
      check("br_fetch_k4", 64'(addr0[4]), 64'd5);

      // not-taken branch and writes to r0
      clear_all();
      imem[0] = itype(OP_ADDI, 5'd1, 5'd0, 16'd4);
      imem[1] = itype(OP_BEQ, 5'd1, 5'd0, 16'd2);
      imem[2] = itype(OP_ADDI, 5'd0, 5'd0, 16'd5);
      imem[3] = rtype(3'b000, 5'd9, 5'd0, 5'd0);
      imem[4] = itype(OP_ADDI, 5'd10, 5'd0, 16'd2);
      push_wb(5'd1, 32'd4);
      push_wb(5'd9, 32'd0);
      push_wb(5'd10, 32'd2);
      run_prog(14);
      check("nt_flush0", 64'(fls0), 64'd0);
      check("nt_flush1", 64'(fls1), 64'd0);
      check("nt_stalls0", 64'(stl0), 64'd0);

      // store data forwarding and 4-bit counter wrap
      clear_all();
      imem[0] = itype(OP_ADDI, 5'd2, 5'd0, 16'hFFFF);
      imem[1] = itype(OP_SW, 5'd2, 5'd0, 16'd8);
      push_wb(5'd2, 32'hFFFF_FFFF);
      push_st(32'd8, 32'hFFFF_FFFF);
      run_prog(20);
      check("sw_stalls1", 64'(stl1), 64'd2);
      check("cnt4_k15", 64'(cyc1[15]), 64'd15);
      check("cnt4_k16_wrap", 64'(cyc1[16]), 64'd0);
      check("cnt32_k16", 64'(cyc0[16]), 64'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
